prmcu_uart_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO buffering 9-bit UART characters between the system side and `prmcu_uart_top`. Instantiated directly upstream of the transmitter: its output valid/ready port connects to `in_dat_i`/`in_vld_i`/`in_rdy_o` of `prmcu_uart_top`, so software can queue a burst of characters while the serializer drains them at line rate. It also exposes a fill level and a programmable threshold flag for interrupt generation.

---
 rtl/prmcu_uart_pkg.sv | 7 +
 rtl/prmcu_fifo_ptr.sv | 17 +
 rtl/prmcu_uart_fifo.sv | 64 ++++++
 tb/tb_prmcu_uart_fifo.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/prmcu_uart_pkg.sv
// Shared widths and types for the PRMCU UART blocks.
package prmcu_uart_pkg;
    localparam int PRMCU_UART_DAT_W      = 9;
    localparam int PRMCU_UART_FIFO_DEPTH = 16;

    typedef logic [PRMCU_UART_DAT_W-1:0] prmcu_uart_dat_t;
endpackage

// File: rtl/prmcu_fifo_ptr.sv
// FIFO pointer with wrap bit; increments on inc, clears on rst or clr.
module prmcu_fifo_ptr #(
    parameter int PW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
    end
endmodule

// File: rtl/prmcu_uart_fifo.sv
// First-word-fall-through character FIFO feeding the UART transmitter,
// with fill level and programmable threshold flag.
module prmcu_uart_fifo
    import prmcu_uart_pkg::*;
#(
    parameter int DEPTH = PRMCU_UART_FIFO_DEPTH,
    parameter int DAT_W = PRMCU_UART_DAT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic [DAT_W-1:0]         in_dat_i,
    input  logic                     in_vld_i,
    output logic                     in_rdy_o,
    output logic [DAT_W-1:0]         out_dat_o,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    input  logic [$clog2(DEPTH):0]   thresh_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     thresh_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DEPTH-1:0][DAT_W-1:0] mem;
    logic [PW-1:0]               wr_ptr, rd_ptr;
    logic                        push, pop;

    // Flush discards any same-cycle transfer; full blocks writes even while popping.
    assign push = in_vld_i && in_rdy_o && !flush_i;
    assign pop  = out_vld_o && out_rdy_i && !flush_i;

    prmcu_fifo_ptr #(.PW(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush_i),
        .inc (push),
        .ptr (wr_ptr)
    );

    prmcu_fifo_ptr #(.PW(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush_i),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Storage is intentionally not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= in_dat_i;
    end

    assign full_o    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty_o   = (wr_ptr == rd_ptr);
    assign level_o   = wr_ptr - rd_ptr;
    assign thresh_o  = (level_o >= thresh_i);
    assign in_rdy_o  = !full_o && !rst;
    assign out_vld_o = !empty_o;
    assign out_dat_o = mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_prmcu_uart_fifo.sv
// Directed + random bench for prmcu_uart_fifo against a queue reference model.
module tb_prmcu_uart_fifo;
    localparam int DEPTH = 8;
    localparam int DAT_W = 9;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic [DAT_W-1:0] in_dat_i;
    logic             in_vld_i;
    logic             in_rdy_o;
    logic [DAT_W-1:0] out_dat_o;
    logic             out_vld_o;
    logic             out_rdy_i;
    logic [LW-1:0]    thresh_i;
    logic [LW-1:0]    level_o;
    logic             full_o;
    logic             empty_o;
    logic             thresh_o;

    int n_chk = 0;
    int n_err = 0;
    int unsigned q[$];

    prmcu_uart_fifo #(.DEPTH(DEPTH), .DAT_W(DAT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .in_dat_i  (in_dat_i),
        .in_vld_i  (in_vld_i),
        .in_rdy_o  (in_rdy_o),
        .out_dat_o (out_dat_o),
        .out_vld_o (out_vld_o),
        .out_rdy_i (out_rdy_i),
        .thresh_i  (thresh_i),
        .level_o   (level_o),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .thresh_o  (thresh_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: predict from the inputs held across the edge, then compare after it.
    task automatic step();
        bit          push_ok, pop_ok, r, f;
        int unsigned d;
        r       = rst;
        f       = flush_i;
        d       = in_dat_i;
        push_ok = in_vld_i && !r && !f && (q.size() < DEPTH);
        pop_ok  = out_rdy_i && !r && !f && (q.size() > 0);
        if (q.size() > 0 && !r) chk("head_dat", out_dat_o, q[0]);
        @(posedge clk);
        if (r || f) q.delete();
        else begin
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back(d);
        end
        #1;
        chk("level", level_o, q.size());
        chk("empty", empty_o, q.size() == 0);
        chk("full", full_o, q.size() == DEPTH);
        chk("out_vld", out_vld_o, q.size() != 0);
        chk("in_rdy", in_rdy_o, !rst && (q.size() < DEPTH));
        chk("thresh", thresh_o, q.size() >= thresh_i);
        if (q.size() > 0) chk("head_dat", out_dat_o, q[0]);
    endtask

    task automatic drive(input bit v, input int unsigned d, input bit r);
        in_vld_i  = v;
        in_dat_i  = d[DAT_W-1:0];
        out_rdy_i = r;
        step();
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_vld_i = 1'b0; in_dat_i = '0;
        out_rdy_i = 1'b0; thresh_i = 4'd0;
        step();
        in_vld_i = 1'b1;
        step();
        chk("rst_in_rdy", in_rdy_o, 1'b0);
        rst = 1'b0; in_vld_i = 1'b0;
        step();

        // Fill and block
        thresh_i = 4'd4;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, i, 1'b0);
        chk("fill_full", full_o, 1'b1);
        chk("fill_level", level_o, DEPTH);
        drive(1'b1, 9'h1AA, 1'b0);
        drive(1'b1, 9'h1AA, 1'b0);

        // Drain order
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 0, 1'b1);
        chk("drain_empty", empty_o, 1'b1);

        // Full with simultaneous push/pop
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 9'h100 + i, 1'b0);
        drive(1'b1, 9'h0F0, 1'b1);
        chk("fullpp_level", level_o, DEPTH - 1);
        drive(1'b1, 9'h0F1, 1'b0);
        chk("fullpp_refill", level_o, DEPTH);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 0, 1'b1);

        // Threshold crossing up then down
        for (int i = 0; i < 4; i++) drive(1'b1, 9'h050 + i, 1'b0);
        chk("thr_rise", thresh_o, 1'b1);
        drive(1'b0, 0, 1'b1);
        chk("thr_fall", thresh_o, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b1);

        // Flush mid-operation with a concurrent push
        for (int i = 0; i < 5; i++) drive(1'b1, 9'h020 + i, 1'b0);
        flush_i = 1'b1;
        drive(1'b1, 9'h0AB, 1'b1);
        flush_i = 1'b0;
        chk("flush_level", level_o, 0);
        chk("flush_vld", out_vld_o, 1'b0);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) drive(1'b1, 9'h030 + i, 1'b0);
        rst = 1'b1;
        drive(1'b1, 9'h0CD, 1'b1);
        chk("rst_level", level_o, 0);
        chk("rst_rdy_hi", in_rdy_o, 1'b0);
        rst = 1'b0;
        drive(1'b0, 0, 1'b0);

        // Random streaming across many pointer wraps
        for (int i = 0; i < 600; i++) begin
            thresh_i = LW'($urandom_range(0, DEPTH));
            flush_i  = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1));
        end
        flush_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
